// File: rtl/stq_addr_ring.sv
// Store-queue address CAM: ring-allocated entries with a per-entry lifecycle and
// NCHK combinational load probes that select the youngest older overlapping store.
module stq_addr_ring #(
    parameter int WIDTH = 36,
    parameter int DEPTH = 32,
    parameter int NCHK  = 6,
    localparam int IW   = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   alloc_en,
    output logic                   alloc_ok,
    output logic [IW-1:0]          alloc_idx,
    input  logic                   wrt_en,
    input  logic [IW-1:0]          wrt_idx,
    input  logic [WIDTH-1:0]       wrt_addrEO,
    input  logic [3:0]             wrt_odd,
    input  logic [3:0]             wrt_bytes,
    input  logic [7:0]             wrt_subBNK,
    input  logic                   upd_en,
    input  logic [IW-1:0]          upd_idx,
    input  logic                   commit_en,
    input  logic                   drain_en,
    input  logic                   excpt,
    input  logic [NCHK-1:0]        chk_en,
    input  logic [NCHK*(IW+1)-1:0] chk_age,
    input  logic [NCHK*WIDTH-1:0]  chk_addrEO,
    input  logic [NCHK*4-1:0]      chk_odd,
    input  logic [NCHK*4-1:0]      chk_bytes,
    input  logic [NCHK*8-1:0]      chk_subBNK,
    output logic [NCHK-1:0]        chk_match,
    output logic [NCHK-1:0]        chk_partial,
    output logic [NCHK*IW-1:0]     chk_idx,
    output logic [IW:0]            count,
    output logic                   full,
    output logic                   empty
);

    typedef enum logic [2:0] {
        ST_FREE  = 3'd0,
        ST_ALLOC = 3'd1,
        ST_ADDR  = 3'd2,
        ST_READY = 3'd3,
        ST_PASSE = 3'd4
    } ent_state_t;

    localparam logic [IW:0] PTR_ONE  = (IW+1)'(1);
    localparam logic [IW:0] FULL_CNT = (IW+1)'(DEPTH);

    ent_state_t       state_reg  [DEPTH];
    ent_state_t       state_next [DEPTH];
    logic             pend_reg   [DEPTH];
    logic             pend_next  [DEPTH];
    logic             avld_reg   [DEPTH];
    logic             avld_next  [DEPTH];
    logic [WIDTH-1:0] addr_reg   [DEPTH];
    logic [3:0]       odd_reg    [DEPTH];
    logic [3:0]       bytes_reg  [DEPTH];
    logic [7:0]       sub_reg    [DEPTH];

    logic [IW:0] head_reg, cmt_reg, tail_reg;
    logic [IW:0] head_next, cmt_next, tail_next;
    logic [IW:0] flush_span;
    logic        commit_do, drain_do, wrt_fld_en;

    // ---------------- pointers and occupancy ----------------
    assign count      = tail_reg - head_reg;
    assign full       = (count == FULL_CNT);
    assign empty      = (count == '0);
    assign alloc_ok   = alloc_en & ~full & ~excpt & ~rst;
    assign alloc_idx  = tail_reg[IW-1:0];
    assign commit_do  = commit_en & (cmt_reg != tail_reg);
    assign drain_do   = drain_en & (head_reg != cmt_reg);
    assign head_next  = drain_do ? head_reg + PTR_ONE : head_reg;
    assign cmt_next   = commit_do ? cmt_reg + PTR_ONE : cmt_reg;
    // A flush rewinds tail to the post-commit pointer, so a same-cycle commit survives.
    assign tail_next  = excpt ? cmt_next : (alloc_ok ? tail_reg + PTR_ONE : tail_reg);
    assign flush_span = tail_reg - cmt_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            head_reg <= '0;
            cmt_reg  <= '0;
            tail_reg <= '0;
        end else begin
            head_reg <= head_next;
            cmt_reg  <= cmt_next;
            tail_reg <= tail_next;
        end
    end

    // ---------------- per-entry lifecycle ----------------
    always_comb begin
        logic live, w_hit, u_hit, in_flush;
        live     = 1'b0;
        w_hit    = 1'b0;
        u_hit    = 1'b0;
        in_flush = 1'b0;
        for (int e = 0; e < DEPTH; e++) begin
            state_next[e] = state_reg[e];
            pend_next[e]  = pend_reg[e];
            avld_next[e]  = avld_reg[e];
            live     = state_reg[e] inside {ST_ALLOC, ST_ADDR, ST_READY};
            w_hit    = wrt_en && (wrt_idx == IW'(e)) && live;
            u_hit    = upd_en && (upd_idx == IW'(e)) && live;
            in_flush = ({1'b0, IW'(e) - cmt_next[IW-1:0]} < flush_span);
            if (w_hit)
                avld_next[e] = 1'b1;
            case (state_reg[e])
                ST_ALLOC: begin
                    if (w_hit)
                        state_next[e] = (u_hit || pend_reg[e]) ? ST_READY : ST_ADDR;
                    else if (u_hit)
                        pend_next[e] = 1'b1;
                end
                ST_ADDR: begin
                    if (u_hit)
                        state_next[e] = ST_READY;
                end
                default: ;
            endcase
            if (drain_do && (head_reg[IW-1:0] == IW'(e))) begin
                state_next[e] = ST_FREE;
            end else if (commit_do && (cmt_reg[IW-1:0] == IW'(e))) begin
                state_next[e] = ST_PASSE;
            end else if (excpt && in_flush) begin
                state_next[e] = ST_FREE;
            end else if (alloc_ok && (tail_reg[IW-1:0] == IW'(e))) begin
                state_next[e] = ST_ALLOC;
                pend_next[e]  = 1'b0;
                avld_next[e]  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int e = 0; e < DEPTH; e++) begin
                state_reg[e] <= ST_FREE;
                pend_reg[e]  <= 1'b0;
                avld_reg[e]  <= 1'b0;
            end
        end else begin
            for (int e = 0; e < DEPTH; e++) begin
                state_reg[e] <= state_next[e];
                pend_reg[e]  <= pend_next[e];
                avld_reg[e]  <= avld_next[e];
            end
        end
    end

    // Payload needs no reset: avld_reg gates every use of it.
    assign wrt_fld_en = wrt_en && (state_reg[wrt_idx] inside {ST_ALLOC, ST_ADDR, ST_READY});

    always_ff @(posedge clk) begin
        if (wrt_fld_en) begin
            addr_reg[wrt_idx]  <= wrt_addrEO;
            odd_reg[wrt_idx]   <= wrt_odd;
            bytes_reg[wrt_idx] <= wrt_bytes;
            sub_reg[wrt_idx]   <= wrt_subBNK;
        end
    end

    // ---------------- load probe ports ----------------
    for (genvar gi = 0; gi < NCHK; gi++) begin : g_chk
        logic [IW:0]        p_age;
        logic [WIDTH-1:0]   p_addr;
        logic [3:0]         p_odd;
        logic [3:0]         p_bytes;
        logic [7:0]         p_sub;
        logic [DEPTH-1:0]   cand;
        logic               found;
        logic [IW-1:0]      sel;
        logic               fwd_ok;
        logic               p_on;

        assign p_age   = chk_age[gi*(IW+1) +: IW+1];
        assign p_addr  = chk_addrEO[gi*WIDTH +: WIDTH];
        assign p_odd   = chk_odd[gi*4 +: 4];
        assign p_bytes = chk_bytes[gi*4 +: 4];
        assign p_sub   = chk_subBNK[gi*8 +: 8];

        always_comb begin
            for (int e = 0; e < DEPTH; e++) begin
                cand[e] = avld_reg[e]
                       && (state_reg[e] inside {ST_ADDR, ST_READY, ST_PASSE})
                       && (addr_reg[e] == p_addr)
                       && (odd_reg[e][0] == p_odd[0])
                       && ((sub_reg[e] & p_sub) != 8'h00);
            end
        end

        // Walk from head towards the probe's age; the last hit seen is the youngest.
        always_comb begin
            logic [IW:0]   span;
            logic [IW-1:0] idx;
            span  = p_age - head_reg;
            idx   = '0;
            found = 1'b0;
            sel   = '0;
            for (int k = 0; k < DEPTH; k++) begin
                idx = head_reg[IW-1:0] + IW'(k);
                if (((IW+1)'(k) < span) && cand[idx]) begin
                    found = 1'b1;
                    sel   = idx;
                end
            end
        end

        assign fwd_ok = (state_reg[sel] inside {ST_READY, ST_PASSE})
                     && ((p_bytes & ~bytes_reg[sel]) == 4'h0)
                     && (odd_reg[sel] == p_odd);
        assign p_on   = chk_en[gi] & ~rst & found;

        assign chk_match[gi]          = p_on & fwd_ok;
        assign chk_partial[gi]        = p_on & ~fwd_ok;
        assign chk_idx[gi*IW +: IW]   = p_on ? sel : '0;
    end

endmodule

// File: tb/tb_stq_addr_ring.sv
// Directed bench for stq_addr_ring: allocation, forwarding select, flush and ring wrap.
module tb_stq_addr_ring;

    localparam int IW = 5;
    localparam int W  = 36;
    localparam int N  = 6;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              alloc_en = 1'b0;
    logic              alloc_ok;
    logic [IW-1:0]     alloc_idx;
    logic              wrt_en = 1'b0;
    logic [IW-1:0]     wrt_idx = '0;
    logic [W-1:0]      wrt_addrEO = '0;
    logic [3:0]        wrt_odd = '0;
    logic [3:0]        wrt_bytes = '0;
    logic [7:0]        wrt_subBNK = '0;
    logic              upd_en = 1'b0;
    logic [IW-1:0]     upd_idx = '0;
    logic              commit_en = 1'b0;
    logic              drain_en = 1'b0;
    logic              excpt = 1'b0;
    logic [N-1:0]      chk_en = '0;
    logic [N*(IW+1)-1:0] chk_age = '0;
    logic [N*W-1:0]    chk_addrEO = '0;
    logic [N*4-1:0]    chk_odd = '0;
    logic [N*4-1:0]    chk_bytes = '0;
    logic [N*8-1:0]    chk_subBNK = '0;
    logic [N-1:0]      chk_match;
    logic [N-1:0]      chk_partial;
    logic [N*IW-1:0]   chk_idx;
    logic [IW:0]       count;
    logic              full;
    logic              empty;

    int tests = 0;
    int fails = 0;

    stq_addr_ring dut (
        .clk(clk), .rst(rst),
        .alloc_en(alloc_en), .alloc_ok(alloc_ok), .alloc_idx(alloc_idx),
        .wrt_en(wrt_en), .wrt_idx(wrt_idx), .wrt_addrEO(wrt_addrEO),
        .wrt_odd(wrt_odd), .wrt_bytes(wrt_bytes), .wrt_subBNK(wrt_subBNK),
        .upd_en(upd_en), .upd_idx(upd_idx),
        .commit_en(commit_en), .drain_en(drain_en), .excpt(excpt),
        .chk_en(chk_en), .chk_age(chk_age), .chk_addrEO(chk_addrEO),
        .chk_odd(chk_odd), .chk_bytes(chk_bytes), .chk_subBNK(chk_subBNK),
        .chk_match(chk_match), .chk_partial(chk_partial), .chk_idx(chk_idx),
        .count(count), .full(full), .empty(empty)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic alloc_n(input int n);
        for (int i = 0; i < n; i++) begin
            alloc_en = 1'b1;
            step();
        end
        alloc_en = 1'b0;
    endtask

    task automatic commit_n(input int n);
        for (int i = 0; i < n; i++) begin
            commit_en = 1'b1;
            step();
        end
        commit_en = 1'b0;
    endtask

    task automatic drain_n(input int n);
        for (int i = 0; i < n; i++) begin
            drain_en = 1'b1;
            step();
        end
        drain_en = 1'b0;
    endtask

    task automatic wrt_one(input logic [IW-1:0] idx, input logic [W-1:0] a, input logic [3:0] od,
                           input logic [3:0] by, input logic [7:0] sb, input logic with_upd);
        wrt_en = 1'b1; wrt_idx = idx; wrt_addrEO = a; wrt_odd = od; wrt_bytes = by; wrt_subBNK = sb;
        upd_en = with_upd; upd_idx = idx;
        step();
        wrt_en = 1'b0; upd_en = 1'b0;
    endtask

    task automatic upd_one(input logic [IW-1:0] idx);
        upd_en = 1'b1; upd_idx = idx;
        step();
        upd_en = 1'b0;
    endtask

    task automatic set_probe(input int p, input logic en, input logic [IW:0] age, input logic [W-1:0] a,
                             input logic [3:0] od, input logic [3:0] by, input logic [7:0] sb);
        chk_en[p] = en;
        chk_age[p*(IW+1) +: IW+1] = age;
        chk_addrEO[p*W +: W] = a;
        chk_odd[p*4 +: 4] = od;
        chk_bytes[p*4 +: 4] = by;
        chk_subBNK[p*8 +: 8] = sb;
    endtask

    task automatic clr_probe();
        chk_en = '0; chk_age = '0; chk_addrEO = '0; chk_odd = '0; chk_bytes = '0; chk_subBNK = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1; alloc_en = 1'b1; commit_en = 1'b1; drain_en = 1'b1;
        #1;
        tests++; if (alloc_ok !== 1'b0) begin fails++; $display("FAIL rst_alloc_ok got %b exp 0", alloc_ok); end
        step();
        rst = 1'b0; alloc_en = 1'b0; commit_en = 1'b0; drain_en = 1'b0;
        for (int p = 0; p < N; p++) set_probe(p, 1'b1, 6'd1, 36'h0, 4'h0, 4'hF, 8'hFF);
        #1;
        tests++; if (count !== 6'd0) begin fails++; $display("FAIL rst_count got %0d exp 0", count); end
        tests++; if (empty !== 1'b1) begin fails++; $display("FAIL rst_empty got %b exp 1", empty); end
        tests++; if (full !== 1'b0) begin fails++; $display("FAIL rst_full got %b exp 0", full); end
        tests++; if (alloc_idx !== 5'd0) begin fails++; $display("FAIL rst_alloc_idx got %0d exp 0", alloc_idx); end
        tests++; if (chk_match !== 6'h0 || chk_partial !== 6'h0 || chk_idx !== 30'h0) begin
            fails++; $display("FAIL rst_chk got m=%h p=%h i=%h exp all 0", chk_match, chk_partial, chk_idx); end
        clr_probe();
        $display("[TB] test_reset done");
    endtask

    task automatic test_alloc_full();
        do_reset();
        for (int i = 0; i < 32; i++) begin
            alloc_en = 1'b1;
            #1;
            tests++; if (alloc_idx !== 5'(i) || alloc_ok !== 1'b1) begin
                fails++; $display("FAIL alloc_idx_%0d got idx=%0d ok=%b exp idx=%0d ok=1", i, alloc_idx, alloc_ok, i); end
            step();
        end
        #1;
        tests++; if (full !== 1'b1) begin fails++; $display("FAIL alloc_full got %b exp 1", full); end
        tests++; if (alloc_ok !== 1'b0) begin fails++; $display("FAIL alloc_33_ok got %b exp 0", alloc_ok); end
        step();
        alloc_en = 1'b0;
        #1;
        tests++; if (count !== 6'd32) begin fails++; $display("FAIL alloc_33_count got %0d exp 32", count); end
        $display("[TB] test_alloc_full done");
    endtask

    task automatic test_forward();
        do_reset();
        alloc_n(1);
        wrt_one(5'd0, 36'h123, 4'h0, 4'hF, 8'h01, 1'b0);
        upd_one(5'd0);
        set_probe(0, 1'b1, 6'd1, 36'h123, 4'h0, 4'h3, 8'h01);
        set_probe(3, 1'b1, 6'd1, 36'h124, 4'h0, 4'h3, 8'h01);
        set_probe(5, 1'b0, 6'd1, 36'h123, 4'h0, 4'h3, 8'h01);
        #1;
        tests++; if (chk_match[0] !== 1'b1 || chk_partial[0] !== 1'b0) begin
            fails++; $display("FAIL fwd_flags got m=%b p=%b exp m=1 p=0", chk_match[0], chk_partial[0]); end
        tests++; if (chk_idx[4:0] !== 5'd0) begin fails++; $display("FAIL fwd_idx got %0d exp 0", chk_idx[4:0]); end
        tests++; if (chk_match[3] !== 1'b0 || chk_partial[3] !== 1'b0) begin
            fails++; $display("FAIL fwd_tagmiss got m=%b p=%b exp 0 0", chk_match[3], chk_partial[3]); end
        tests++; if (chk_match[5] !== 1'b0 || chk_partial[5] !== 1'b0 || chk_idx[29:25] !== 5'd0) begin
            fails++; $display("FAIL fwd_chk_en0 got m=%b p=%b exp 0 0", chk_match[5], chk_partial[5]); end
        clr_probe();
        $display("[TB] test_forward done");
    endtask

    task automatic test_partial();
        do_reset();
        alloc_n(1);
        // Probe during the writeback cycle: the address is not yet visible.
        set_probe(0, 1'b1, 6'd1, 36'h123, 4'h0, 4'h3, 8'h01);
        wrt_en = 1'b1; wrt_idx = 5'd0; wrt_addrEO = 36'h123; wrt_odd = 4'h0; wrt_bytes = 4'hF; wrt_subBNK = 8'h01;
        #1;
        tests++; if (chk_match[0] !== 1'b0 || chk_partial[0] !== 1'b0) begin
            fails++; $display("FAIL part_same_cycle got m=%b p=%b exp 0 0", chk_match[0], chk_partial[0]); end
        step();
        wrt_en = 1'b0;
        #1;
        tests++; if (chk_partial[0] !== 1'b1 || chk_match[0] !== 1'b0) begin
            fails++; $display("FAIL part_no_data got m=%b p=%b exp m=0 p=1", chk_match[0], chk_partial[0]); end
        do_reset();
        alloc_n(1);
        wrt_one(5'd0, 36'h123, 4'h0, 4'h3, 8'h01, 1'b0);
        upd_one(5'd0);
        set_probe(0, 1'b1, 6'd1, 36'h123, 4'h0, 4'hF, 8'h01);
        #1;
        tests++; if (chk_partial[0] !== 1'b1 || chk_match[0] !== 1'b0) begin
            fails++; $display("FAIL part_bytes got m=%b p=%b exp m=0 p=1", chk_match[0], chk_partial[0]); end
        set_probe(0, 1'b1, 6'd1, 36'h123, 4'h0, 4'h2, 8'h01);
        #1;
        tests++; if (chk_match[0] !== 1'b1) begin fails++; $display("FAIL part_subset got m=%b exp 1", chk_match[0]); end
        do_reset();
        alloc_n(1);
        wrt_one(5'd0, 36'h777, 4'b0010, 4'hF, 8'h10, 1'b1);
        set_probe(0, 1'b1, 6'd1, 36'h777, 4'b0000, 4'h1, 8'h30);
        #1;
        tests++; if (chk_partial[0] !== 1'b1 || chk_match[0] !== 1'b0) begin
            fails++; $display("FAIL part_odd got m=%b p=%b exp m=0 p=1", chk_match[0], chk_partial[0]); end
        set_probe(0, 1'b1, 6'd1, 36'h777, 4'b0011, 4'h1, 8'h30);
        #1;
        tests++; if (chk_partial[0] !== 1'b0 || chk_match[0] !== 1'b0) begin
            fails++; $display("FAIL part_odd0 got m=%b p=%b exp 0 0", chk_match[0], chk_partial[0]); end
        clr_probe();
        $display("[TB] test_partial done");
    endtask

    task automatic test_youngest();
        do_reset();
        alloc_n(2);
        upd_one(5'd0);
        wrt_one(5'd0, 36'hA_BCDE_1234, 4'h0, 4'hF, 8'h01, 1'b0);
        wrt_one(5'd1, 36'hA_BCDE_1234, 4'h0, 4'hF, 8'h03, 1'b1);
        set_probe(2, 1'b1, 6'd2, 36'hA_BCDE_1234, 4'h0, 4'hF, 8'h01);
        #1;
        tests++; if (chk_idx[14:10] !== 5'd1 || chk_match[2] !== 1'b1) begin
            fails++; $display("FAIL young_age2 got idx=%0d m=%b exp idx=1 m=1", chk_idx[14:10], chk_match[2]); end
        set_probe(2, 1'b1, 6'd1, 36'hA_BCDE_1234, 4'h0, 4'hF, 8'h01);
        #1;
        tests++; if (chk_idx[14:10] !== 5'd0 || chk_match[2] !== 1'b1) begin
            fails++; $display("FAIL young_age1 got idx=%0d m=%b exp idx=0 m=1", chk_idx[14:10], chk_match[2]); end
        set_probe(2, 1'b1, 6'd0, 36'hA_BCDE_1234, 4'h0, 4'hF, 8'h01);
        #1;
        tests++; if (chk_match[2] !== 1'b0 || chk_partial[2] !== 1'b0) begin
            fails++; $display("FAIL young_age_head got m=%b p=%b exp 0 0", chk_match[2], chk_partial[2]); end
        set_probe(2, 1'b1, 6'd2, 36'hA_BCDE_1234, 4'h0, 4'hF, 8'h02);
        #1;
        tests++; if (chk_idx[14:10] !== 5'd1 || chk_match[2] !== 1'b1) begin
            fails++; $display("FAIL young_subbnk got idx=%0d m=%b exp idx=1 m=1", chk_idx[14:10], chk_match[2]); end
        clr_probe();
        $display("[TB] test_youngest done");
    endtask

    task automatic test_excpt();
        do_reset();
        alloc_n(5);
        commit_n(2);
        excpt = 1'b1; alloc_en = 1'b1;
        #1;
        tests++; if (alloc_ok !== 1'b0) begin fails++; $display("FAIL exc_alloc_ok got %b exp 0", alloc_ok); end
        step();
        excpt = 1'b0; alloc_en = 1'b0;
        #1;
        tests++; if (count !== 6'd2 || alloc_idx !== 5'd2) begin
            fails++; $display("FAIL exc_count got cnt=%0d tail=%0d exp cnt=2 tail=2", count, alloc_idx); end
        drain_n(2);
        tests++; if (empty !== 1'b1) begin fails++; $display("FAIL exc_drain_empty got %b exp 1", empty); end
        drain_n(1);
        tests++; if (count !== 6'd0 || alloc_idx !== 5'd2) begin
            fails++; $display("FAIL exc_drain_extra got cnt=%0d tail=%0d exp cnt=0 tail=2", count, alloc_idx); end
        // head=2: alloc 3 (tail 5), commit 1 (cmt 3), then commit+excpt keeps entry 3
        alloc_n(3);
        commit_n(1);
        commit_en = 1'b1; excpt = 1'b1;
        step();
        commit_en = 1'b0; excpt = 1'b0;
        tests++; if (count !== 6'd2 || alloc_idx !== 5'd4) begin
            fails++; $display("FAIL exc_commit_same got cnt=%0d tail=%0d exp cnt=2 tail=4", count, alloc_idx); end
        alloc_n(1);
        commit_en = 1'b1; drain_en = 1'b1;
        step();
        commit_en = 1'b0; drain_en = 1'b0;
        tests++; if (count !== 6'd2) begin fails++; $display("FAIL cmt_drain_same got %0d exp 2", count); end
        alloc_en = 1'b1; drain_en = 1'b1;
        step();
        alloc_en = 1'b0; drain_en = 1'b0;
        tests++; if (count !== 6'd2 || alloc_idx !== 5'd6) begin
            fails++; $display("FAIL alloc_drain_same got cnt=%0d tail=%0d exp cnt=2 tail=6", count, alloc_idx); end
        $display("[TB] test_excpt done");
    endtask

    task automatic test_wrap();
        do_reset();
        for (int i = 0; i < 63; i++) begin
            alloc_n(1);
            commit_n(1);
            drain_n(1);
        end
        tests++; if (alloc_idx !== 5'd31 || empty !== 1'b1) begin
            fails++; $display("FAIL wrap_tail got idx=%0d empty=%b exp idx=31 empty=1", alloc_idx, empty); end
        alloc_n(2);
        wrt_one(5'd31, 36'hF_0000_0042, 4'h1, 4'hF, 8'h80, 1'b1);
        wrt_one(5'd0, 36'hF_0000_0042, 4'h1, 4'hF, 8'h80, 1'b1);
        tests++; if (count !== 6'd2) begin fails++; $display("FAIL wrap_count got %0d exp 2", count); end
        set_probe(1, 1'b1, 6'd1, 36'hF_0000_0042, 4'h1, 4'h5, 8'hC0);
        #1;
        tests++; if (chk_idx[9:5] !== 5'd0 || chk_match[1] !== 1'b1) begin
            fails++; $display("FAIL wrap_young got idx=%0d m=%b exp idx=0 m=1", chk_idx[9:5], chk_match[1]); end
        set_probe(1, 1'b1, 6'd0, 36'hF_0000_0042, 4'h1, 4'h5, 8'hC0);
        #1;
        tests++; if (chk_idx[9:5] !== 5'd31 || chk_match[1] !== 1'b1) begin
            fails++; $display("FAIL wrap_older got idx=%0d m=%b exp idx=31 m=1", chk_idx[9:5], chk_match[1]); end
        set_probe(1, 1'b1, 6'd63, 36'hF_0000_0042, 4'h1, 4'h5, 8'hC0);
        #1;
        tests++; if (chk_match[1] !== 1'b0 || chk_partial[1] !== 1'b0) begin
            fails++; $display("FAIL wrap_none got m=%b p=%b exp 0 0", chk_match[1], chk_partial[1]); end
        clr_probe();
        $display("[TB] test_wrap done");
    endtask

    initial begin
        test_reset();
        test_alloc_full();
        test_forward();
        test_partial();
        test_youngest();
        test_excpt();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
